moore_stim_sequencer: RTL and testbench
=======================================

Name: moore_stim_sequencer

Overview:
- Controller that sequences the Moore sequence-detector datapath from the top-level wrapper.
- Latches a parallel test pattern and presents it to the detector one bit per programmable tick on fsm_bit/fsm_valid.
- After each bit, samples the detector's Moore output fsm_match and accumulates a saturating match count.
- Signals busy/done to the top level so pattern runs can be launched from ui_in and read back on uo_out.

Parameters:
- PAT_W, 8, pattern length in bits (2..16).
- CNT_W, 4, match counter width.
- DIV_W, 8, tick divider width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; 0 freezes all state.
- start  input  1  launch request, level-sampled.
- pattern  input  PAT_W  bits to shift out; latched on accepted start.
- lsb_first  input  1  shift order; 1 = bit 0 first; latched on accepted start.
- div  input  DIV_W  extra wait cycles before each bit; latched on accepted start.
- fsm_bit  output  1  serial bit to the detector.
- fsm_valid  output  1  one-cycle strobe; the detector advances state on this edge.
- fsm_match  input  1  detector Moore output.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start.
- match_cnt  output  CNT_W  number of matches in the current or last run.
- match_seen  output  1  sticky; at least one match in the current or last run.

Behaviour:
- Reset: asynchronous on rst_n=0. Clears state to IDLE, the shift register, bit index, divider counter, match_cnt and match_seen. All outputs read 0. A reset mid-run aborts the run; no strobe is issued during or after reset.
- States: IDLE, SHIFT, SAMPLE, DONE.
  - busy = (SHIFT or SAMPLE).
  - done = DONE.
- Start acceptance:
  - Accepted when start=1 and ena=1 in IDLE or DONE.
  - Next cycle: SHIFT, with shift register = pattern, order/div latched, idx = 0, divcnt = div, match_cnt = 0, match_seen = 0.
  - start while busy is ignored.
- SHIFT:
  - If divcnt != 0: decrement.
  - If divcnt == 0: fsm_valid=1 for this cycle, then go to SAMPLE.
  - fsm_valid is combinational: (state==SHIFT && divcnt==0 && ena).
- fsm_bit:
  - Combinational: sr[0] if lsb_first is latched, else sr[PAT_W-1].
  - Driven in every state; 0 in IDLE after reset.
- SAMPLE (exactly 1 cycle):
  - fsm_match already reflects the bit just clocked into the detector, because the Moore output follows its state.
  - If fsm_match=1: match_cnt increments, saturating at 2^CNT_W-1, and match_seen is set.
  - Shift sr toward the consumed end, filling with 0; reload divcnt = div.
  - If idx == PAT_W-1, go to DONE; else idx++ and go to SHIFT.
- Timing: each bit takes div+2 cycles. busy lasts PAT_W*(div+2) cycles; done rises on the next cycle.
- DONE: done=1, and match_cnt and match_seen hold. A new accepted start re-enters SHIFT directly and clears both.
- ena=0: no state, counter or register changes; fsm_valid forced 0; start ignored. Resuming continues exactly where it stopped.
- Simultaneous events:
  - fsm_match is only sampled in SAMPLE; its value in other states is ignored.
  - start in the same cycle as SAMPLE→DONE is ignored (busy still 1 in that cycle).
- Widths: idx is $clog2(PAT_W) bits, and divcnt is DIV_W bits. The divider does not wrap, since it is reloaded on every bit.

Decomposition:
- Package moore_seq_pkg holds:
  - state enum: IDLE=2'd0, SHIFT=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - default widths PAT_W/CNT_W/DIV_W;
  - saturating-increment constant CNT_MAX.
- One natural sub-module, moore_tick_div: a loadable down-counter with load/enable inputs and a zero output, instanced for divcnt. The FSM, shift register and counters stay in the top.

Test Plan:
- Reset mid-run: start with pattern=8'hA5, div=0. Drop rst_n after 5 cycles → busy, done, match_cnt and fsm_valid are 0 asynchronously, with no further strobes; the following start runs normally.
- Basic timing: pattern=8'b1011_0010, lsb_first=0, div=0, bench holds fsm_match=0.
  - Exactly 8 fsm_valid pulses, 2 cycles apart.
  - fsm_bit sequence 1,0,1,1,0,0,1,0.
  - busy for 16 cycles; done on cycle 17; match_cnt=0.
- Match counting: attach a "101" Moore detector model.
  - pattern=8'b1010_1010, lsb_first=0 → match_cnt=3, match_seen=1.
  - Same pattern, lsb_first=1 → order 0,1,0,1,0,1,0,1 → match_cnt=3.
- Divider and saturation, in one run: PAT_W=16, CNT_W=2, div=3, fsm_match tied 1.
  - 16 pulses, 5 cycles apart; busy for 80 cycles.
  - match_cnt saturates at 3.
- Protocol and freeze:
  - start held high during the run → no restart until DONE, then an immediate rerun with match_cnt cleared.
  - ena=0 for 7 cycles during SHIFT with div=2 → no pulses, counters frozen; total busy length = 32 + 7 cycles.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared state encoding and default widths for the Moore stimulus sequencer
package moore_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;
    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 4;
    localparam int DIV_W_DEF = 8;
    localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;
endpackage

// File: rtl/moore_tick_div.sv
// moore_tick_div: loadable down-counter that paces each bit of a stimulus run
module moore_tick_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (ena) cnt <= load ? load_val : (dec && !zero) ? cnt - 1'b1 : cnt;
    end
endmodule

// File: rtl/moore_stim_sequencer.sv
// moore_stim_sequencer: shifts a latched pattern into a Moore detector and counts its matches
module moore_stim_sequencer
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic             lsb_first,
    input  logic [DIV_W-1:0] div,
    output logic             fsm_bit,
    output logic             fsm_valid,
    input  logic             fsm_match,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             match_seen
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
    state_t state, state_n;
    logic [PAT_W-1:0] sr;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx;
    logic lsb_q, accept, div_zero, last;
    assign accept = ena && start && (state == IDLE || state == DONE);
    assign last = idx == LAST_IDX;
    assign busy = state == SHIFT || state == SAMPLE;
    assign done = state == DONE;
    assign fsm_valid = ena && state == SHIFT && div_zero;
    assign fsm_bit = lsb_q ? sr[0] : sr[PAT_W-1];
    moore_tick_div #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (accept || state == SAMPLE),
        .dec      (state == SHIFT),
        .load_val (accept ? div : div_q),
        .zero     (div_zero)
    );
    // every transition is gated by ena so a frozen cycle holds the state
    always_comb begin
        state_n = state;
        if (accept) state_n = SHIFT;
        else if (ena && state == SHIFT && div_zero) state_n = SAMPLE;
        else if (ena && state == SAMPLE) state_n = last ? DONE : SHIFT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            div_q      <= '0;
            idx        <= '0;
            lsb_q      <= 1'b0;
            match_cnt  <= '0;
            match_seen <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                sr         <= pattern;
                lsb_q      <= lsb_first;
                div_q      <= div;
                idx        <= '0;
                match_cnt  <= '0;
                match_seen <= 1'b0;
            end else if (ena && state == SAMPLE) begin
                sr  <= lsb_q ? sr >> 1 : sr << 1;
                idx <= last ? idx : idx + 1'b1;
                if (fsm_match) begin
                    match_cnt  <= match_cnt == '1 ? match_cnt : match_cnt + 1'b1;
                    match_seen <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_moore_stim_sequencer.sv
// tb_moore_stim_sequencer: scoreboard bench with a "101" Moore detector and random runs
module tb_moore_stim_sequencer;
    localparam int PW = 8, CW = 4, DW = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {int cnt; int seen; int blen;} res_t;

    logic clk = 0, rst_n = 0, ena = 1, start = 0, lsb_first = 0;
    logic [PW-1:0] pattern = '0;
    logic [DW-1:0] div = '0;
    logic fsm_bit, fsm_valid, fsm_match, busy, done, match_seen;
    logic [CW-1:0] match_cnt;

    logic start2 = 0;
    logic [15:0] pattern2 = '0;
    logic fsm_bit2, fsm_valid2, busy2, done2, match_seen2;
    logic [1:0] match_cnt2;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pulses = 0, busy_len = 0, last_pulse = -1;
    int gap_exp = 2, run_id = 0, det_id = 0, mode = 0, k = 0;
    bit sb_on = 0, gap_chk = 1;
    logic done_d = 0, busy_d = 0, js = 0, noise = 0;
    logic [2:0] det_hist = '0;
    logic [PW-1:0] rv = '0;
    logic bit_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    moore_stim_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .pattern(pattern),
        .lsb_first(lsb_first), .div(div), .fsm_bit(fsm_bit), .fsm_valid(fsm_valid),
        .fsm_match(fsm_match), .busy(busy), .done(done), .match_cnt(match_cnt),
        .match_seen(match_seen)
    );

    moore_stim_sequencer #(.PAT_W(16), .CNT_W(2), .DIV_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .pattern(pattern2),
        .lsb_first(1'b0), .div(8'd3), .fsm_bit(fsm_bit2), .fsm_valid(fsm_valid2),
        .fsm_match(1'b1), .busy(busy2), .done(done2), .match_cnt(match_cnt2),
        .match_seen(match_seen2)
    );

    // mode 0: held 0, 1: "101" detector, 2: held 1, 3: random per bit with noise between bits
    assign fsm_match = mode == 1 ? det_hist == 3'b101 :
                       mode == 2 ? 1'b1 :
                       mode == 3 ? (js ? rv[k-1] : noise) : 1'b0;

    always @(posedge clk) begin
        noise <= 1'($urandom);
        if (det_id != run_id) begin
            det_hist <= '0;
            k <= 0;
            js <= 1'b0;
            det_id <= run_id;
        end else if (ena) begin
            js <= fsm_valid;
            if (fsm_valid) begin
                det_hist <= {det_hist[1:0], fsm_bit};
                k <= k + 1;
            end
        end
    end

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void exp_push(logic [PW-1:0] pat, logic lsb, int dv, int md, int frz,
                                     logic [PW-1:0] r);
        logic s [PW];
        int raw = 0;
        res_t e;
        for (int i = 0; i < PW; i++) begin
            s[i] = lsb ? pat[i] : pat[PW-1-i];
            bit_q.push_back(s[i]);
            if (md == 2) raw++;
            if (md == 3 && r[i]) raw++;
        end
        if (md == 1)
            for (int i = 2; i < PW; i++) if (s[i-2] && !s[i-1] && s[i]) raw++;
        e.cnt = raw > CMAX ? CMAX : raw;
        e.seen = raw > 0 ? 1 : 0;
        e.blen = PW * (dv + 2) + frz;
        res_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            busy_len = 0;
            last_pulse = -1;
        end else begin
            if (busy) busy_len++;
            if (fsm_valid) begin
                pulses++;
                if (sb_on) begin
                    if (bit_q.size() == 0) check("strobe_expected", bit_q.size(), 1);
                    else check("fsm_bit", fsm_bit, bit_q.pop_front());
                    if (gap_chk && last_pulse >= 0) check("strobe_gap", cyc - last_pulse, gap_exp);
                    last_pulse = cyc;
                end
            end
            if (done && !done_d && sb_on) begin
                check("done_after_busy", busy_d, 1);
                if (res_q.size() == 0) check("result_expected", res_q.size(), 1);
                else begin
                    e = res_q.pop_front();
                    check("busy_len", busy_len, e.blen);
                    check("match_cnt", match_cnt, e.cnt);
                    check("match_seen", match_seen, e.seen);
                end
                busy_len = 0;
                last_pulse = -1;
            end
        end
        done_d = done;
        busy_d = busy;
    end

    task automatic wait_done(int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic launch(logic [PW-1:0] pat, logic lsb, int dv, int md, int frz, bit hold);
        logic [PW-1:0] r;
        int mc;
        r = PW'($urandom);
        exp_push(pat, lsb, dv, md, frz, r);
        if (hold) exp_push(pat, lsb, dv, md, frz, r);
        @(negedge clk);
        rv = r;
        mode = md;
        run_id++;
        pattern = pat;
        lsb_first = lsb;
        div = DW'(dv);
        gap_exp = dv + 2;
        gap_chk = frz == 0;
        start = 1;
        @(negedge clk);
        if (!hold) start = 0;
        if (frz > 0) begin
            repeat (dv + 2) @(negedge clk);
            ena = 0;
            mc = match_cnt;
            repeat (frz) begin
                @(negedge clk);
                check("freeze_valid", fsm_valid, 0);
                check("freeze_busy", busy, 1);
                check("freeze_cnt", match_cnt, mc);
            end
            ena = 1;
        end
        wait_done(PW * (dv + 2) + frz + 20);
        if (hold) begin
            @(negedge clk);
            start = 0;
            check("rerun_busy", busy, 1);
            check("rerun_cnt_clear", match_cnt, 0);
            wait_done(PW * (dv + 2) + 20);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int p0, t, np, b2, lp, gerr, berr;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", fsm_valid, 0);
        check("rst_bit", fsm_bit, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_seen", match_seen, 0);
        rst_n = 1;
        @(negedge clk);

        // run aborted by reset after a few cycles
        pattern = 8'hA5;
        div = '0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", busy, 1);
        #2 rst_n = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", fsm_valid, 0);
        check("abort_cnt", match_cnt, 0);
        check("abort_seen", match_seen, 0);
        p0 = pulses;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("no_strobe_after_abort", pulses, p0);
        check("idle_after_abort", busy, 0);
        sb_on = 1;

        launch(8'b1011_0010, 0, 0, 0, 0, 0);
        launch(8'b1010_1010, 0, 0, 1, 0, 0);
        launch(8'b1010_1010, 1, 0, 1, 0, 0);
        launch(8'h5C, 0, 0, 2, 0, 1);
        launch(8'h3B, 1, 2, 2, 7, 0);
        for (int i = 0; i < 10; i++)
            launch(PW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                   $urandom_range(0, 3), 0, 0);
        launch(8'hFF, 0, 0, 2, 0, 0);

        // divider and saturation on a 16-bit, 2-bit-counter instance
        @(negedge clk);
        pattern2 = 16'($urandom);
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        t = 0; np = 0; b2 = 0; lp = -1; gerr = 0; berr = 0;
        while (!done2 && t < 200) begin
            if (busy2) b2++;
            if (fsm_valid2) begin
                if (lp >= 0 && cyc - lp != 5) gerr++;
                if (np < 16 && fsm_bit2 != pattern2[15-np]) berr++;
                lp = cyc;
                np++;
            end
            @(negedge clk);
            t++;
        end
        check("sat_done", done2, 1);
        check("sat_pulses", np, 16);
        check("sat_busy_len", b2, 80);
        check("sat_gap_errors", gerr, 0);
        check("sat_bit_errors", berr, 0);
        check("sat_cnt", match_cnt2, 3);
        check("sat_seen", match_seen2, 1);

        repeat (2) @(negedge clk);
        check("bits_drained", bit_q.size(), 0);
        check("results_drained", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
